// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types, defaults and helpers for the adder scheduler
package adder_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_ADD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // ceil(log2(n)); clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at rr_ptr
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_valid,
    input  logic [IDW-1:0] rr_ptr,
    output logic           any_valid,
    output logic [IDW-1:0] winner
);

    int idx;

    // Scan offsets from farthest to nearest so the rr_ptr-nearest valid requester wins last
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - round-robin scheduler sharing one registered adder among requesters
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_out,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    // wait_cnt holds values 0..ADD_LAT
    localparam int CNT_W = (ADD_LAT < 2) ? 1 : clog2(ADD_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [CNT_W-1:0]   wait_cnt;
    logic               any_valid;
    logic [ID_W-1:0]    winner;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .winner    (winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count out adder latency in WAIT, hold in RESP until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_valid)        state_nxt = WAIT;
            WAIT: if (wait_cnt == '0)   state_nxt = RESP;
            RESP: if (rsp_ready)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Grant is a combinational one-hot of the winner, only in IDLE and never while in reset
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && any_valid) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Operand capture, latency countdown, response capture and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            wait_cnt  <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        add_a    <= req_a[winner*WIDTH +: WIDTH];
                        add_b    <= req_b[winner*WIDTH +: WIDTH];
                        grant_id <= winner;
                        wait_cnt <= CNT_W'(ADD_LAT);
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        rsp_data  <= add_out;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/adder_scheduler.md
Name: adder_scheduler

Overview:
- Shares one registered 4-bit adder datapath (`clk`, `a`, `b` -> registered `out` = a+b) between NUM_REQ requesters.
- Arbitrates round-robin, drives the adder operands, and waits the adder latency.
- Returns the truncated sum with the winning requester's id over a valid/ready response channel.
- Sits between requester logic and the shared adder instance; one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/result width, matches adder ports
- ADD_LAT, 1, clock edges from operands stable at adder input to add_out valid (0 = combinational adder)
- ID_W, 2, width of rsp_id, equals clog2(NUM_REQ)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  flattened operand a, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  flattened operand b, same packing
- add_a  out  WIDTH  registered operand a to shared adder
- add_b  out  WIDTH  registered operand b to shared adder
- add_out  in  WIDTH  shared adder result
- rsp_valid  out  1  response valid
- rsp_id  out  ID_W  index of requester that owns the response
- rsp_data  out  WIDTH  captured sum
- rsp_ready  in  1  response consumer accept
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, grant_id=0, wait_cnt=0.
  - add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready is combinational, so it is all 0 whenever rst_n is low.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other bits 0; all 0 if no req_valid.
  - On the edge with valid&ready: add_a<=req_a[winner], add_b<=req_b[winner], grant_id<=winner, wait_cnt<=ADD_LAT, go WAIT.
- WAIT:
  - req_ready all 0; add_a/add_b held stable.
  - If wait_cnt!=0, decrement.
  - If wait_cnt==0: rsp_data<=add_out, rsp_id<=grant_id, rsp_valid<=1, go RESP.
  - WAIT therefore lasts ADD_LAT+1 cycles.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, add_a, add_b held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, go IDLE.
- Latency: accept edge E0 -> rsp_valid high after edge E0+ADD_LAT+1. Default: 2 cycles.
- Minimum issue interval: ADD_LAT+3 cycles.
- Arithmetic: sum is modulo 2^WIDTH (the adder truncates); no carry out is reported.
- Requester rules:
  - A requester holds req_a/req_b stable while req_valid=1.
  - A requester may drop req_valid before acceptance.
  - The scheduler re-arbitrates every IDLE cycle; no grant state is kept across IDLE cycles.
- Fairness: after serving i, requester i has lowest priority next round. A continuously requesting set of k requesters is served in strict rotation.
- Simultaneous events:
  - All requesters valid in IDLE: only the rr_ptr-nearest is accepted.
  - A new req_valid in WAIT/RESP is not accepted until IDLE.
  - rsp_ready high outside RESP is ignored.
- Reset mid-operation: the in-flight transaction is dropped, no response is issued, and rr_ptr returns to 0.
- busy = (state != IDLE).

Decomposition:
- Package adder_sched_pkg:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - default WIDTH/NUM_REQ constants
  - clog2 function
- Sub-module rr_pick (combinational):
  - inputs: req_valid, rr_ptr
  - outputs: any_valid, winner index
  - reused by later shared-resource schedulers.

Test Plan:
- Single request: req 0 a=2 b=1, ADD_LAT=1, rsp_ready=1 -> req_ready[0] in the same cycle; 2 cycles after accept rsp_valid=1, rsp_id=0, rsp_data=3.
- Overflow: req 2 a=4'hF b=4'h2 -> rsp_data=1, rsp_id=2.
- Round-robin: all 4 req_valid held high with a=i, b=1, rsp_ready=1 -> responses in id order 0,1,2,3,0; data i+1; each issue interval 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready all 0; busy=1; completes one cycle after rsp_ready=1.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 immediately; no rsp_valid after release; the next request from req 3 is accepted (rr_ptr=0, only requester valid).
- ADD_LAT=0 build: a=5 b=6 -> rsp_valid 1 cycle after accept, rsp_data=11.
